// File: rtl/rfg_axis_protocol_initiator.sv
// rtl/rfg_axis_protocol_initiator.sv - RFG register-protocol initiator: command in, AXIS frame out, read data back
//
// Purpose: serializes register transactions from on-chip logic into RFG
// protocol frames (header, address, length lo, length hi, optional write
// payload) on an AXIS byte master. Read-response bytes from the responder
// arrive on an AXIS byte slave and are passed through to the rd stream,
// framed by the requested length.
//
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   cmd_*                    command request (valid/ready handshake)
//   wr_tdata/tvalid/tready   write payload stream into the initiator
//   rd_tdata/tvalid/tready/tlast  read payload stream out of the initiator
//   m_axis_*                 frame bytes to the responder (registered)
//   s_axis_*                 response bytes from the responder
//   busy                     transaction in progress
//   done                     one-cycle pulse on the final byte handshake
//   err_cmd                  one-cycle pulse after an illegal command
//   err_timeout              one-cycle pulse when the read response stalls
module rfg_axis_protocol_initiator #(
  parameter logic [7:0]  SOURCE_ID      = 8'h01,
  parameter logic [7:0]  DEST_ID        = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_read,
  input  logic        cmd_incr,
  input  logic [3:0]  cmd_vchannel,
  input  logic [7:0]  cmd_address,
  input  logic [15:0] cmd_length,
  input  logic [7:0]  wr_tdata,
  input  logic        wr_tvalid,
  output logic        wr_tready,
  output logic [7:0]  rd_tdata,
  output logic        rd_tvalid,
  input  logic        rd_tready,
  output logic        rd_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [7:0]  m_axis_tid,
  output logic [7:0]  m_axis_tdest,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic        busy,
  output logic        done,
  output logic        err_cmd,
  output logic        err_timeout
);

  typedef enum logic [2:0] {IDLE, HEADER, ADDRESS, LENA, LENB, WDATA, RDATA} state_t;

  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1;

  state_t      state, state_next;
  logic [7:0]  address_q, address_next;
  logic [15:0] length_q, length_next;
  logic        is_read_q, is_read_next;
  logic [15:0] count, count_next;
  logic [31:0] timer, timer_next;
  logic [7:0]  tdata_next;
  logic        tvalid_next, tlast_next, err_cmd_next;
  logic        m_hs, s_hs, wr_hs;

  // The response framing is driven purely by the byte count.
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;

  assign m_axis_tid   = SOURCE_ID;
  assign m_axis_tdest = DEST_ID;

  assign m_hs  = m_axis_tvalid && m_axis_tready;
  assign s_hs  = s_axis_tvalid && s_axis_tready;
  assign wr_hs = wr_tvalid && wr_tready;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Payload may load while the LENB byte is leaving, so writes run without a
  // bubble between the header phase and the first payload byte.
  assign wr_tready = ((state == WDATA) && (count != 16'd0) && (!m_axis_tvalid || m_axis_tready)) ||
                     ((state == LENB) && !is_read_q && m_axis_tready);

  // Outside a read, stray response bytes are drained so the interconnect never stalls.
  assign s_axis_tready = (state == RDATA) ? rd_tready : 1'b1;
  assign rd_tvalid     = (state == RDATA) && s_axis_tvalid;
  assign rd_tdata      = (state == RDATA) ? s_axis_tdata : 8'h00;
  assign rd_tlast      = (state == RDATA) && (count == 16'd1);

  assign done = ((state == WDATA) && m_hs && m_axis_tlast) ||
                ((state == RDATA) && s_hs && (count == 16'd1));
  assign err_timeout = TIMEOUT_EN && (state == RDATA) && !s_hs && (timer == TIMEOUT_LAST);

  always_comb begin
    state_next   = state;
    address_next = address_q;
    length_next  = length_q;
    is_read_next = is_read_q;
    count_next   = count;
    timer_next   = timer;
    tdata_next   = m_axis_tdata;
    tvalid_next  = m_axis_tvalid;
    tlast_next   = m_axis_tlast;
    err_cmd_next = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          address_next = cmd_address;
          length_next  = cmd_length;
          is_read_next = cmd_read;
          if ((cmd_write == cmd_read) || (cmd_length == 16'd0)) begin
            err_cmd_next = 1'b1;
          end else begin
            state_next  = HEADER;
            tdata_next  = {cmd_vchannel, 1'b0, cmd_incr, cmd_read, cmd_write};
            tvalid_next = 1'b1;
            tlast_next  = 1'b0;
          end
        end
      end
      HEADER: if (m_hs) begin
        tdata_next = address_q;
        state_next = ADDRESS;
      end
      ADDRESS: if (m_hs) begin
        tdata_next = length_q[7:0];
        state_next = LENA;
      end
      LENA: if (m_hs) begin
        tdata_next = length_q[15:8];
        tlast_next = is_read_q;
        state_next = LENB;
      end
      LENB: if (m_hs) begin
        count_next = length_q;
        timer_next = 32'd0;
        if (is_read_q) begin
          state_next  = RDATA;
          tvalid_next = 1'b0;
          tlast_next  = 1'b0;
        end else begin
          state_next = WDATA;
          if (wr_tvalid) begin
            tdata_next = wr_tdata;
            tlast_next = (length_q == 16'd1);
            count_next = length_q - 16'd1;
          end else begin
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
          end
        end
      end
      WDATA: begin
        if (m_hs && m_axis_tlast) begin
          state_next  = IDLE;
          tvalid_next = 1'b0;
          tlast_next  = 1'b0;
        end else if (wr_hs) begin
          tdata_next  = wr_tdata;
          tvalid_next = 1'b1;
          tlast_next  = (count == 16'd1);
          count_next  = count - 16'd1;
        end else if (m_hs) begin
          tvalid_next = 1'b0;
        end
      end
      RDATA: begin
        if (s_hs) begin
          timer_next = 32'd0;
          count_next = count - 16'd1;
          if (count == 16'd1) state_next = IDLE;
        end else if (err_timeout) begin
          state_next = IDLE;
        end else begin
          timer_next = timer + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      address_q     <= 8'h00;
      length_q      <= 16'h0000;
      is_read_q     <= 1'b0;
      count         <= 16'h0000;
      timer         <= 32'd0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      err_cmd       <= 1'b0;
    end else begin
      state         <= state_next;
      address_q     <= address_next;
      length_q      <= length_next;
      is_read_q     <= is_read_next;
      count         <= count_next;
      timer         <= timer_next;
      m_axis_tdata  <= tdata_next;
      m_axis_tvalid <= tvalid_next;
      m_axis_tlast  <= tlast_next;
      err_cmd       <= err_cmd_next;
    end
  end

endmodule

// File: tb/tb_rfg_axis_protocol_initiator.sv
// tb/tb_rfg_axis_protocol_initiator.sv - self-checking bench for rfg_axis_protocol_initiator
module tb_rfg_axis_protocol_initiator;
  localparam int TO = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_read = 1'b0, cmd_incr = 1'b0;
  logic [3:0]  cmd_vchannel = 4'h0;
  logic [7:0]  cmd_address = 8'h00;
  logic [15:0] cmd_length = 16'h0000;
  logic [7:0]  wr_tdata;
  logic        wr_tvalid, wr_tready;
  logic [7:0]  rd_tdata;
  logic        rd_tvalid, rd_tready, rd_tlast;
  logic [7:0]  m_axis_tdata, m_axis_tid, m_axis_tdest;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic        busy, done, err_cmd, err_timeout;

  always #5 aclk = ~aclk;

  rfg_axis_protocol_initiator #(.SOURCE_ID(8'h01), .DEST_ID(8'h00), .TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_read(cmd_read),
    .cmd_incr(cmd_incr), .cmd_vchannel(cmd_vchannel), .cmd_address(cmd_address), .cmd_length(cmd_length),
    .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
    .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready), .rd_tlast(rd_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .busy(busy), .done(done), .err_cmd(err_cmd), .err_timeout(err_timeout)
  );

  // Expected frame beats {release_response, first, last, data}, expected rd beats {last, data}.
  logic [10:0] exp_m[$];
  logic [8:0]  exp_rd[$];
  logic [7:0]  wr_q[$], s_q[$], resp_pend[$];

  int n_pass = 0, n_total = 0;
  int cyc = 0, done_cnt = 0, errc_cnt = 0, errt_cnt = 0, rd_beats = 0;
  int first_cyc = 0, last_cyc = 0, last_s_cyc = 0;
  int tready_mode = 0, gap_pct = 0, s_gap_pct = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [7:0] hdr(bit w, bit r, bit incr, logic [3:0] vch);
    return {vch, 1'b0, incr, r, w};
  endfunction

  // Frame model: header, address, len lo, len hi, then the payload for writes.
  task automatic prepare(bit w, bit incr, logic [3:0] vch, logic [7:0] addr, logic [15:0] len);
    exp_m.push_back({3'b010, hdr(w, !w, incr, vch)});
    exp_m.push_back({3'b000, addr});
    exp_m.push_back({3'b000, len[7:0]});
    exp_m.push_back({!w, 1'b0, !w, len[15:8]});
    if (w) begin
      for (int i = 0; i < wr_q.size(); i++) exp_m.push_back({2'b00, (i == int'(len) - 1), wr_q[i]});
    end else begin
      for (int i = 0; i < resp_pend.size(); i++) exp_rd.push_back({(i == int'(len) - 1), resp_pend[i]});
    end
  endtask

  task automatic issue(bit w, bit r, bit incr, logic [3:0] vch, logic [7:0] addr, logic [15:0] len);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge aclk); n++; end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge aclk); #1;
    cmd_write = w; cmd_read = r; cmd_incr = incr; cmd_vchannel = vch;
    cmd_address = addr; cmd_length = len; cmd_valid = 1'b1;
    @(negedge aclk);
    chk("cmd_ready_at_accept", 32'(cmd_ready), 32'd1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    do begin @(negedge aclk); n++; end while (busy && n < budget);
    chk("busy_cleared", 32'(busy), 32'd0);
  endtask

  task automatic go(bit w, bit incr, logic [3:0] vch, logic [7:0] addr, logic [15:0] len,
                    int exp_done, int exp_errt);
    int d0, t0;
    d0 = done_cnt; t0 = errt_cnt;
    issue(w, !w, incr, vch, addr, len);
    wait_idle(4000);
    repeat (2) @(negedge aclk);
    chk("done_pulses", 32'(done_cnt - d0), 32'(exp_done));
    chk("err_timeout_pulses", 32'(errt_cnt - t0), 32'(exp_errt));
    chk("frame_beats_left", 32'(exp_m.size()), 32'd0);
    chk("rd_beats_left", 32'(exp_rd.size()), 32'd0);
  endtask

  // Ready generators for the master side and the read-data sink.
  initial begin
    m_axis_tready = 1'b0; rd_tready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      case (tready_mode)
        0: begin m_axis_tready = 1'b1; rd_tready = 1'b1; end
        1: begin m_axis_tready = ~m_axis_tready; rd_tready = ($urandom_range(0, 99) < 80); end
        default: begin m_axis_tready = ($urandom_range(0, 99) < 70); rd_tready = ($urandom_range(0, 99) < 80); end
      endcase
    end
  end

  // Write payload source with random gaps; holds data until accepted.
  initial begin : wr_drv
    bit hs;
    wr_tvalid = 1'b0; wr_tdata = 8'h00;
    forever begin
      @(negedge aclk);
      hs = wr_tvalid && wr_tready;
      @(posedge aclk); #1;
      if (hs && wr_q.size() > 0) void'(wr_q.pop_front());
      if (wr_q.size() == 0) wr_tvalid = 1'b0;
      else begin
        if (hs || !wr_tvalid) wr_tvalid = ($urandom_range(0, 99) >= gap_pct);
        wr_tdata = wr_q[0];
      end
    end
  end

  // Responder model: sends queued response bytes with random gaps.
  initial begin : s_drv
    bit hs;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0;
    forever begin
      @(negedge aclk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge aclk); #1;
      if (hs && s_q.size() > 0) void'(s_q.pop_front());
      if (s_q.size() == 0) s_axis_tvalid = 1'b0;
      else begin
        if (hs || !s_axis_tvalid) begin
          s_axis_tvalid = ($urandom_range(0, 99) >= s_gap_pct);
          s_axis_tlast  = 1'($urandom_range(0, 1));
        end
        s_axis_tdata = s_q[0];
      end
    end
  end

  // Compare process: checks every cycle against the expectation queues.
  initial begin : cmp
    bit          prev_stall;
    logic [8:0]  prev_beat;
    logic [10:0] b;
    logic [8:0]  r;
    prev_stall = 1'b0; prev_beat = 9'h000;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin prev_stall = 1'b0; continue; end
      if (prev_stall) begin
        chk("m_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("m_hold_data", 32'({m_axis_tlast, m_axis_tdata}), 32'(prev_beat));
      end
      if (exp_m.size() == 0) chk("m_tvalid_unexpected", 32'(m_axis_tvalid), 32'd0);
      else if (m_axis_tvalid && m_axis_tready) begin
        b = exp_m.pop_front();
        chk("m_tdata", 32'(m_axis_tdata), 32'(b[7:0]));
        chk("m_tlast", 32'(m_axis_tlast), 32'(b[8]));
        chk("m_tid", 32'(m_axis_tid), 32'h01);
        chk("m_tdest", 32'(m_axis_tdest), 32'h00);
        if (b[9]) first_cyc = cyc;
        if (b[8]) last_cyc = cyc;
        if (b[10]) while (resp_pend.size() > 0) s_q.push_back(resp_pend.pop_front());
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};

      if (s_axis_tvalid && s_axis_tready) last_s_cyc = cyc;
      if (exp_rd.size() == 0) chk("rd_tvalid_unexpected", 32'(rd_tvalid), 32'd0);
      else if (rd_tvalid && rd_tready) begin
        r = exp_rd.pop_front();
        chk("rd_tdata", 32'(rd_tdata), 32'(r[7:0]));
        chk("rd_tlast", 32'(rd_tlast), 32'(r[8]));
        rd_beats++;
      end
      if (done) done_cnt++;
      if (err_cmd) errc_cnt++;
      if (err_timeout) begin
        errt_cnt++;
        chk("timeout_latency", 32'(cyc - last_s_cyc), 32'(TO));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, e0, rb0, len;
    bit w;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_s_tready", 32'(s_axis_tready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_wr_tready", 32'(wr_tready), 32'd0);
    chk("rst_pulses", 32'({done, err_cmd, err_timeout}), 32'd0);
    chk("rst_tid", 32'(m_axis_tid), 32'h01);
    chk("rst_tdest", 32'(m_axis_tdest), 32'h00);

    // Write burst, full rate.
    tready_mode = 0; gap_pct = 0; s_gap_pct = 0;
    wr_q = '{8'hA1, 8'hA2, 8'hA3};
    prepare(1'b1, 1'b1, 4'd2, 8'h10, 16'd3);
    chk("model_wr_hdr", 32'(exp_m[0][7:0]), 32'h25);
    chk("model_wr_addr", 32'(exp_m[1][7:0]), 32'h10);
    chk("model_wr_lena", 32'(exp_m[2][7:0]), 32'h03);
    chk("model_wr_last", 32'(exp_m[6]), 32'h1A3);
    go(1'b1, 1'b1, 4'd2, 8'h10, 16'd3, 1, 0);
    chk("wr_burst_cycles", 32'(last_cyc - first_cyc + 1), 32'd7);

    // Read burst.
    resp_pend = '{8'h5A, 8'h5B};
    prepare(1'b0, 1'b0, 4'd0, 8'h04, 16'd2);
    chk("model_rd_hdr", 32'(exp_m[0][7:0]), 32'h02);
    chk("model_rd_lenb", 32'(exp_m[3]), 32'h500);
    chk("model_rd_tlast", 32'(exp_rd[1]), 32'h15B);
    go(1'b0, 1'b0, 4'd0, 8'h04, 16'd2, 1, 0);

    // Backpressure: toggling tready, gapped payload.
    tready_mode = 1; gap_pct = 40; s_gap_pct = 20;
    for (int i = 0; i < 4; i++) wr_q.push_back(8'($urandom));
    prepare(1'b1, 1'b0, 4'd5, 8'h33, 16'd4);
    go(1'b1, 1'b0, 4'd5, 8'h33, 16'd4, 1, 0);

    // Illegal commands.
    tready_mode = 0; gap_pct = 0; s_gap_pct = 0;
    d0 = done_cnt; e0 = errc_cnt;
    issue(1'b1, 1'b1, 1'b0, 4'd1, 8'h20, 16'd5);
    repeat (3) @(negedge aclk);
    chk("err_cmd_both", 32'(errc_cnt - e0), 32'd1);
    chk("err_cmd_ready", 32'(cmd_ready), 32'd1);
    issue(1'b1, 1'b0, 1'b0, 4'd1, 8'h20, 16'd0);
    repeat (3) @(negedge aclk);
    chk("err_cmd_len0", 32'(errc_cnt - e0), 32'd2);
    chk("err_cmd_busy", 32'(busy), 32'd0);
    chk("err_cmd_no_done", 32'(done_cnt - d0), 32'd0);

    // Timeout: one response byte of three.
    resp_pend = '{8'h77};
    prepare(1'b0, 1'b0, 4'd0, 8'h40, 16'd3);
    go(1'b0, 1'b0, 4'd0, 8'h40, 16'd3, 0, 1);
    s_q.push_back(8'hEE);
    repeat (6) @(negedge aclk);
    chk("stray_drained", 32'(s_q.size()), 32'd0);
    wr_q = '{8'h01, 8'h02};
    prepare(1'b1, 1'b1, 4'd3, 8'h50, 16'd2);
    go(1'b1, 1'b1, 4'd3, 8'h50, 16'd2, 1, 0);

    // 256-byte read under random backpressure.
    tready_mode = 2; s_gap_pct = 20;
    for (int i = 0; i < 256; i++) resp_pend.push_back(8'($urandom));
    prepare(1'b0, 1'b0, 4'd0, 8'hAA, 16'h0100);
    chk("model_256_lena", 32'(exp_m[2][7:0]), 32'h00);
    chk("model_256_lenb", 32'(exp_m[3][7:0]), 32'h01);
    rb0 = rd_beats;
    go(1'b0, 1'b0, 4'd0, 8'hAA, 16'h0100, 1, 0);
    chk("rd_256_beats", 32'(rd_beats - rb0), 32'd256);

    // Random mix.
    for (int t = 0; t < 10; t++) begin
      tready_mode = $urandom_range(0, 2);
      gap_pct = $urandom_range(0, 50);
      s_gap_pct = (tready_mode == 0) ? 0 : 20;
      w = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        if (w) wr_q.push_back(8'($urandom));
        else resp_pend.push_back(8'($urandom));
      end
      prepare(w, 1'($urandom_range(0, 1)), 4'(t), 8'($urandom), 16'(len));
      go(w, exp_m[0][2], 4'(t), exp_m[1][7:0], 16'(len), 1, 0);
    end

    // Reset in the middle of a write frame.
    tready_mode = 0; gap_pct = 0; s_gap_pct = 0;
    for (int i = 0; i < 10; i++) wr_q.push_back(8'($urandom));
    prepare(1'b1, 1'b0, 4'd7, 8'h60, 16'd10);
    issue(1'b1, 1'b0, 1'b0, 4'd7, 8'h60, 16'd10);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b0;
    exp_m.delete(); wr_q.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    resp_pend = '{8'hC3};
    prepare(1'b0, 1'b1, 4'd1, 8'h70, 16'd1);
    go(1'b0, 1'b1, 4'd1, 8'h70, 16'd1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
